// File: rtl/pipe_pkg.sv
// Shared types and constants for pipeline boundary stages.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } st_e;

  // ADD x0,x0,x0: harmless filler for downstream decode/execute.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0033;

endpackage

// File: rtl/pipe_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module pipe_sat_cnt #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_skid_stage.sv
// Valid/ready pipeline boundary register with a 1-entry skid buffer and bubble-on-empty output.
// Optional perf counters enabled by defining PIPE_SKID_PERF_EN.
module pipe_skid_stage
  import pipe_pkg::*;
#(
  parameter int unsigned       WIDTH        = 32,
  parameter logic [WIDTH-1:0]  BUBBLE_VALUE = WIDTH'(NOP_INSTR),
  parameter int unsigned       CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PIPE_SKID_PERF_EN
  output logic [CNT_W-1:0] perf_stall_cnt,
  output logic [CNT_W-1:0] perf_kill_cnt,
`endif
  output logic [WIDTH-1:0] out_data
);

  st_e              state_q, state_d;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic             valid_q;
  logic             in_fire, out_fire;

  assign in_ready = ~rst & (state_q != FULL);
  assign in_fire  = in_valid & in_ready;
  assign out_fire = valid_q & out_ready;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = ONE;
          main_d  = in_data;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          main_d = in_data;
        end else if (in_fire) begin
          state_d = FULL;
          skid_d  = in_data;
        end else if (out_fire) begin
          state_d = EMPTY;
          main_d  = BUBBLE_VALUE;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_d = ONE;
          main_d  = skid_q;
          skid_d  = BUBBLE_VALUE;
        end
      end
      default: begin
        state_d = EMPTY;
        main_d  = BUBBLE_VALUE;
        skid_d  = BUBBLE_VALUE;
      end
    endcase
    // Flush overrides everything, including a beat accepted this cycle.
    if (flush) begin
      state_d = EMPTY;
      main_d  = BUBBLE_VALUE;
      skid_d  = BUBBLE_VALUE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= BUBBLE_VALUE;
      skid_q  <= BUBBLE_VALUE;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      valid_q <= (state_d != EMPTY);
    end
  end

  assign out_valid = valid_q;
  assign out_data  = main_q;

`ifdef PIPE_SKID_PERF_EN
  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_stall_cnt (
    .clk(clk),
    .clr(rst),
    .inc(valid_q & ~out_ready),
    .cnt(perf_stall_cnt)
  );

  pipe_sat_cnt #(
    .CNT_W(CNT_W)
  ) u_kill_cnt (
    .clk(clk),
    .clr(rst),
    .inc(flush & (state_q != EMPTY)),
    .cnt(perf_kill_cnt)
  );
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios plus randomized traffic
// checked against a two-entry FIFO reference model.
module tb_pipe_skid_stage;

  localparam int unsigned W  = 32;
  localparam int unsigned CW = 4;
  localparam logic [W-1:0] BUB = 32'h0000_0033;

  logic          clk = 1'b0;
  logic          rst, flush, in_valid, out_ready;
  logic [W-1:0]  in_data;
  logic          in_ready, out_valid;
  logic [W-1:0]  out_data;
`ifdef PIPE_SKID_PERF_EN
  logic [CW-1:0] perf_stall_cnt, perf_kill_cnt;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: contents of the stage in order, oldest first, capacity 2.
  logic [W-1:0] mq[$];
  int           m_stall = 0;
  int           m_kill  = 0;

  pipe_skid_stage #(
    .WIDTH(W),
    .BUBBLE_VALUE(BUB),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
`ifdef PIPE_SKID_PERF_EN
    .perf_stall_cnt(perf_stall_cnt),
    .perf_kill_cnt(perf_kill_cnt),
`endif
    .out_data(out_data)
  );

  always #5 clk = ~clk;

  // Drive one cycle's inputs, advance the model across the rising edge, return at the falling edge.
  task automatic cycle(input logic r, input logic v, input logic f, input logic o,
                       input logic [W-1:0] d);
    bit in_f, out_f;
    rst = r; in_valid = v; flush = f; out_ready = o; in_data = d;
    in_f  = !r && v && (mq.size() < 2);
    out_f = (mq.size() > 0) && o;
    if (r) begin
      m_stall = 0;
      m_kill  = 0;
      mq.delete();
    end else begin
      if ((mq.size() > 0) && !o && (m_stall < 15)) m_stall++;
      if (f && (mq.size() > 0) && (m_kill < 15)) m_kill++;
      if (out_f) void'(mq.pop_front());
      if (in_f) mq.push_back(d);
      if (f) mq.delete();
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h1234);
    cycle(1'b1, 1'b1, 1'b0, 1'b1, 32'h5678);
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_data !== BUB) begin bad++;
      $display("FAIL reset_data got=%h want=%h", out_data, BUB); end
    total++; if (in_ready !== 1'b0) begin bad++;
      $display("FAIL reset_in_ready got=%0b want=0", in_ready); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (in_ready !== 1'b1) begin bad++;
      $display("FAIL post_reset_in_ready got=%0b want=1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++;
      $display("FAIL post_reset_valid got=%0b want=0", out_valid); end
  endtask

  task automatic test_stream();
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b1, W'(i));
      total++; if (out_valid !== 1'b1 || out_data !== W'(i)) begin bad++;
        $display("FAIL stream_beat%0d got=%0b/%h want=1/%h", i, out_valid, out_data, W'(i)); end
      total++; if (in_ready !== 1'b1) begin bad++;
        $display("FAIL stream_ready%0d got=%0b want=1", i, in_ready); end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (out_valid !== 1'b0 || out_data !== BUB) begin bad++;
      $display("FAIL stream_drain got=%0b/%h want=0/%h", out_valid, out_data, BUB); end
  endtask

  task automatic test_backpressure();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hA);
    total++; if (out_data !== 32'hA || in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_first got=%h/%0b want=a/1", out_data, in_ready); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hB);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hA || in_ready !== 1'b0) begin bad++;
      $display("FAIL bp_full got=%0b/%h/%0b want=1/a/0", out_valid, out_data, in_ready); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hF);
    total++; if (out_data !== 32'hA || in_ready !== 1'b0) begin bad++;
      $display("FAIL bp_hold got=%h/%0b want=a/0", out_data, in_ready); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (out_valid !== 1'b1 || out_data !== 32'hB || in_ready !== 1'b1) begin bad++;
      $display("FAIL bp_drain_a got=%0b/%h/%0b want=1/b/1", out_valid, out_data, in_ready); end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (out_valid !== 1'b0 || out_data !== BUB) begin bad++;
      $display("FAIL bp_drain_b got=%0b/%h want=0/%h", out_valid, out_data, BUB); end
  endtask

  task automatic test_flush();
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hC);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'hD);
    total++; if (in_ready !== 1'b0) begin bad++;
      $display("FAIL flush_prefill got=%0b want=0", in_ready); end
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 32'hE);
    total++; if (out_valid !== 1'b0 || out_data !== BUB) begin bad++;
      $display("FAIL flush_bubble got=%0b/%h want=0/%h", out_valid, out_data, BUB); end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
      total++; if (out_valid !== 1'b0 || out_data !== BUB || in_ready !== 1'b1) begin bad++;
        $display("FAIL flush_after%0d got=%0b/%h/%0b want=0/%h/1", i, out_valid, out_data,
                 in_ready, BUB); end
    end
  endtask

  task automatic test_random();
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_data  = '0;
    logic         v, o, f;
    logic [W-1:0] exp_data;
    for (int i = 0; i < 10000; i++) begin
      v = 1'($urandom_range(0, 1));
      o = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      f = ($urandom_range(0, 63) == 0);
      cycle(1'b0, v, f, o, $urandom);
      exp_data = (mq.size() > 0) ? mq[0] : BUB;
      total++; if (out_valid !== (mq.size() > 0) || out_data !== exp_data) begin bad++;
        $display("FAIL rand_out cyc=%0d got=%0b/%h want=%0b/%h", i, out_valid, out_data,
                 mq.size() > 0, exp_data); end
      total++; if (in_ready !== (mq.size() < 2)) begin bad++;
        $display("FAIL rand_ready cyc=%0d got=%0b want=%0b", i, in_ready, mq.size() < 2); end
      if (prev_stall) begin
        total++; if (out_data !== prev_data) begin bad++;
          $display("FAIL rand_stable cyc=%0d got=%h want=%h", i, out_data, prev_data); end
      end
      // Next cycle's stall condition is judged on the inputs driven there; record what it holds now.
      prev_data  = out_data;
      prev_stall = 1'b0;
      if (out_valid) begin
        o = ($urandom_range(0, 3) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        if (!o) begin
          cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
          total++; if (out_data !== prev_data || out_valid !== 1'b1) begin bad++;
            $display("FAIL rand_stall_hold cyc=%0d got=%0b/%h want=1/%h", i, out_valid,
                     out_data, prev_data); end
          prev_data = out_data;
        end
      end
    end
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, '0);
    total++; if (out_valid !== 1'b0 || mq.size() != 0) begin bad++;
      $display("FAIL rand_final_drain got=%0b want=0", out_valid); end
  endtask

`ifdef PIPE_SKID_PERF_EN
  task automatic test_perf();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0);
    total++; if (perf_stall_cnt !== '0 || perf_kill_cnt !== '0) begin bad++;
      $display("FAIL perf_reset got=%h/%h want=0/0", perf_stall_cnt, perf_kill_cnt); end
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 32'h77);
    for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0);
    total++; if (perf_stall_cnt !== CW'(m_stall) || perf_stall_cnt !== 4'hF) begin bad++;
      $display("FAIL perf_stall got=%h want=%h", perf_stall_cnt, CW'(m_stall)); end
    cycle(1'b0, 1'b0, 1'b1, 1'b0, '0);
    total++; if (perf_kill_cnt !== CW'(m_kill) || perf_kill_cnt !== 4'h1) begin bad++;
      $display("FAIL perf_kill got=%h want=%h", perf_kill_cnt, CW'(m_kill)); end
    cycle(1'b0, 1'b0, 1'b1, 1'b1, '0);
    total++; if (perf_kill_cnt !== 4'h1) begin bad++;
      $display("FAIL perf_kill_empty got=%h want=1", perf_kill_cnt); end
  endtask
`endif

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
`ifdef PIPE_SKID_PERF_EN
    test_perf();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
